mul_product_accumulator: RTL
============================

Name: mul_product_accumulator

Overview:
- Downstream consumer of the 8x8 shift-add multiplier's 16-bit product.
- Sums a frame of `len` products into a wide accumulator using a valid/ready handshake, then presents the result until the sink accepts it.
- Forms the accumulate half of a multiply-accumulate datapath.

Parameters:
- ACC_W, 24: accumulator/result width in bits; must be >= 16.

Ports:
- clk  input  1  clock; all state updates on its rising edge
- areset  input  1  reset; synchronous, active-high
- start  input  1  begin new frame; sampled in IDLE, or in HOLD when acc_ready=1
- len  input  8  products in frame; sampled with start; 0 legal
- product  input  16  unsigned multiplier result
- prod_valid  input  1  product is valid this cycle
- prod_ready  output  1  block accepts product this cycle
- acc_sum  output  ACC_W  accumulated result
- acc_valid  output  1  acc_sum is final; held until acc_ready
- acc_ready  input  1  sink accepts acc_sum
- busy  output  1  frame in progress (ACCUM or HOLD)
- overflow  output  1  sticky; carry out of ACC_W occurred in current frame

Behaviour:
- Reset: areset=1 at a clock edge forces the following on the next edge, overriding everything:
  - state=IDLE, acc_sum=0, remaining=0, overflow=0, acc_valid=0, prod_ready=0, busy=0.
  - Reset mid-frame aborts the frame; no partial result is emitted.
- States: IDLE, ACCUM, HOLD. prod_ready, acc_valid and busy are registered state decodes.
- Transfer: prod_valid & prod_ready in the same cycle. Product is zero-extended to ACC_W.
- IDLE (prod_ready=0, acc_valid=0, busy=0):
  - On start: acc_sum<=0, overflow<=0, remaining<=len.
  - len!=0 -> ACCUM. len==0 -> HOLD, giving acc_valid=1 one cycle after start.
- ACCUM (prod_ready=1, busy=1, acc_valid=0):
  - Each transfer: acc_sum<=acc_sum+product, remaining<=remaining-1.
  - Transfer with remaining==1 -> HOLD.
  - Cycles with prod_valid=0 change nothing; product is ignored.
  - start is ignored.
- HOLD (acc_valid=1, busy=1, prod_ready=0):
  - acc_sum and overflow are held stable.
  - acc_ready=1 & start=0 -> IDLE.
  - acc_ready=1 & start=1 -> new frame starts directly; same rules as IDLE+start.
  - start with acc_ready=0 is ignored.
- Latency: acc_valid rises the cycle after the final transfer. Throughput is one product per cycle.
- Arithmetic: unsigned. Without the optional feature, acc_sum wraps mod 2^ACC_W. Any carry out of bit ACC_W-1 sets overflow until the next frame start or reset.
- remaining counts down only; it never wraps, because len==0 bypasses ACCUM.

Optional Feature:
- Macro: ACC_SATURATE_EN.
- Defined: if a transfer would carry out, acc_sum<=all-ones (2^ACC_W-1) and overflow<=1. Later additions keep acc_sum at all-ones.
- Undefined: wrap-around as described above; overflow still flags the carry.

Test Plan:
- Basic (ACC_W=24): reset, start len=3, products 0x0006, 0x00FF, 0xFFFF on consecutive cycles -> acc_valid the cycle after the third transfer, acc_sum=0x010104, overflow=0, busy=1 until acc_ready.
- Gaps: same frame with prod_valid low for 2 cycles between products, product driven to 0xAAAA while invalid -> acc_sum=0x010104, no change during gaps.
- Zero length: start len=0 -> acc_valid=1 and acc_sum=0 one cycle later, prod_ready never 1.
- Overflow (ACC_W=16): len=2, products 0xFFFF then 0x0002 -> without macro acc_sum=0x0001, overflow=1; with ACC_SATURATE_EN acc_sum=0xFFFF, overflow=1.
- Mid-frame reset: start len=4, one transfer of 0x0010, then areset=1 for one cycle -> next cycle busy=0, acc_sum=0, overflow=0. New frame len=1, product 0x0005 -> acc_sum=0x000005.
- Backpressure/back-to-back:
  - HOLD with acc_ready=0 for 5 cycles plus start pulses -> acc_valid and acc_sum stable, start ignored.
  - Then acc_ready=1 & start=1 with len=1 -> next cycle ACCUM with acc_sum=0, prod_ready=1.

Source files
------------

// File: rtl/mul_product_accumulator.sv
// mul_product_accumulator
// Sums a frame of `len` unsigned 16-bit multiplier products into an ACC_W-bit
// accumulator. The result is presented on acc_sum/acc_valid until the sink
// takes it with acc_ready.
//
// Handshakes (valid/ready): a product transfers on a rising edge where
// prod_valid & prod_ready are both 1. A result transfers on a rising edge where
// acc_valid & acc_ready are both 1. Once a valid is raised, its data is held
// stable until that transfer happens.
//
// Optional build macro ACC_SATURATE_EN: an addition that would carry out of
// ACC_W bits clamps acc_sum to all-ones. Without the macro, acc_sum wraps
// modulo 2^ACC_W. In both builds, overflow records the carry.
//
// ACC_W must be at least 16.
module mul_product_accumulator #(
  parameter int ACC_W = 24
) (
  input  logic             clk,
  input  logic             areset,
  input  logic             start,
  input  logic [7:0]       len,
  input  logic [15:0]      product,
  input  logic             prod_valid,
  output logic             prod_ready,
  output logic [ACC_W-1:0] acc_sum,
  output logic             acc_valid,
  input  logic             acc_ready,
  output logic             busy,
  output logic             overflow
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_t;

  // state is the FSM observation point for checkers.
  state_t           state;
  state_t           state_next;
  logic [7:0]       remaining;
  logic [ACC_W:0]   sum_ext;
  logic             carry;
  logic [ACC_W-1:0] sum_next;
  logic             xfer;
  logic             frame_start;

  // A product is consumed only on a full valid/ready transfer.
  assign xfer = prod_valid & prod_ready;

  // A new frame may begin from IDLE, or from HOLD in the same cycle the result is taken.
  assign frame_start = start & ((state == IDLE) | ((state == HOLD) & acc_ready));

  // Adder with one extra bit so the carry out of ACC_W bits is visible.
  always_comb begin
    sum_ext = {1'b0, acc_sum} + {{(ACC_W - 15){1'b0}}, product};
    carry   = sum_ext[ACC_W];
`ifdef ACC_SATURATE_EN
    sum_next = carry ? {ACC_W{1'b1}} : sum_ext[ACC_W-1:0];
`else
    sum_next = sum_ext[ACC_W-1:0];
`endif
  end

  // Next-state decode. A zero-length frame skips ACCUM, so remaining never wraps.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (frame_start) state_next = (len == 8'd0) ? HOLD : ACCUM;
      end
      ACCUM: begin
        if (xfer && (remaining == 8'd1)) state_next = HOLD;
      end
      HOLD: begin
        if (acc_ready) begin
          if (frame_start) state_next = (len == 8'd0) ? HOLD : ACCUM;
          else             state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // State, datapath and registered output decodes.
  always_ff @(posedge clk) begin
    if (areset) begin
      state      <= IDLE;
      acc_sum    <= '0;
      remaining  <= '0;
      overflow   <= 1'b0;
      prod_ready <= 1'b0;
      acc_valid  <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state      <= state_next;
      prod_ready <= (state_next == ACCUM);
      acc_valid  <= (state_next == HOLD);
      busy       <= (state_next != IDLE);
      if (frame_start) begin
        acc_sum   <= '0;
        overflow  <= 1'b0;
        remaining <= len;
      end else if (xfer) begin
        acc_sum   <= sum_next;
        overflow  <= overflow | carry;
        remaining <= remaining - 8'd1;
      end
    end
  end

endmodule
